pipe_field_collision: RTL and testbench

//  Consumer of the bird's 8-row one-hot column position. Scrolls pipe columns

---
 rtl/flappy_pkg.sv | 12 +
 rtl/pipe_lfsr.sv | 17 +
 rtl/pipe_field_collision.sv | 103 ++++++++++
 tb/tb_pipe_field_collision.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy game blocks.
package flappy_pkg;
  localparam int ROWS = 8;
  // Fibonacci taps 8,6,5,4 as a mask over q[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;
endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; steps every clock.
module pipe_lfsr
  import flappy_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
)(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/pipe_field_collision.sv
// Scrolling pipe field, collision detect, score and game state machine.
//   state | meaning
//   IDLE  | waiting for first start press, field dark
//   PLAY  | field scrolls on cycle ticks, collisions checked
//   OVER  | field and score frozen until next start press
module pipe_field_collision #(
  parameter int         ROWS     = flappy_pkg::ROWS,
  parameter int         COLS     = 16,
  parameter int         BIRD_COL = 2,
  parameter int         GAP      = 3,
  parameter int         SPACING  = 4,
  parameter logic [7:0] SEED     = 8'hA5
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cycle,
  input  logic [ROWS-1:0]      bird_pos,
  output logic [COLS*ROWS-1:0] pipes,
  output logic [6:0]           score,
  output logic                 playing,
  output logic                 game_over
);
  import flappy_pkg::*;

  localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int NGAP = ROWS - GAP + 1;
  localparam logic [ROWS-1:0] GAP_ONES = {ROWS{1'b1}} >> (ROWS - GAP);

  game_state_t          state, state_nxt;
  logic [COLS*ROWS-1:0] pipes_nxt;
  logic [6:0]           score_nxt;
  logic [CW-1:0]        spacing_cnt, spacing_cnt_nxt;
  logic                 start_q;
  logic                 start_rise;
  logic                 collision;
  logic [7:0]           lfsr;
  logic [7:0]           gap_lo;
  logic [ROWS-1:0]      bird_col_bits;
  logic [ROWS-1:0]      entry_col;

  pipe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign start_rise    = start & ~start_q;
  assign bird_col_bits = pipes[BIRD_COL*ROWS +: ROWS];
  assign collision     = (state == PLAY) && |(bird_col_bits & bird_pos);
  assign gap_lo        = lfsr % 8'(NGAP);
  assign entry_col     = (spacing_cnt == '0) ? ~(GAP_ONES << gap_lo) : '0;

  always_comb begin
    state_nxt       = state;
    pipes_nxt       = pipes;
    score_nxt       = score;
    spacing_cnt_nxt = spacing_cnt;
    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_nxt       = PLAY;
          pipes_nxt       = '0;
          score_nxt       = '0;
          spacing_cnt_nxt = '0;
        end
      end
      PLAY: begin
        // collision freezes everything on its clock, even a scroll tick
        if (collision) begin
          state_nxt = OVER;
        end else if (cycle) begin
          pipes_nxt = {entry_col, pipes[COLS*ROWS-1:ROWS]};
          if (spacing_cnt == '0) spacing_cnt_nxt = CW'(SPACING - 1);
          else                   spacing_cnt_nxt = spacing_cnt - 1'b1;
          if (bird_col_bits != '0)
            score_nxt = (score >= 7'd99) ? 7'd99 : score + 7'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pipes       <= '0;
      score       <= '0;
      spacing_cnt <= '0;
      start_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pipes       <= pipes_nxt;
      score       <= score_nxt;
      spacing_cnt <= spacing_cnt_nxt;
      start_q     <= start;
    end
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_pipe_field_collision.sv
// Directed bench for pipe_field_collision with a reference model and scoreboard.
module tb_pipe_field_collision;
  localparam int ROWS = 8;
  localparam int COLS = 16;
  localparam int BC   = 2;
  localparam int GAP  = 3;
  localparam int SP   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 cycle = 1'b0;
  logic [ROWS-1:0]      bird_pos = '0;
  logic [COLS*ROWS-1:0] pipes;
  logic [6:0]           score;
  logic                 playing;
  logic                 game_over;

  pipe_field_collision #(
    .ROWS(ROWS), .COLS(COLS), .BIRD_COL(BC), .GAP(GAP), .SPACING(SP), .SEED(SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cycle     (cycle),
    .bird_pos  (bird_pos),
    .pipes     (pipes),
    .score     (score),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COLS*ROWS-1:0] pipes;
    logic [6:0]           score;
    logic                 playing;
    logic                 game_over;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [ROWS-1:0] m_col [COLS];
  int              m_score;
  int              m_st;      // 0 idle, 1 play, 2 over
  int              m_cnt;
  logic [7:0]      m_lfsr;
  logic            m_sq;

  function automatic logic [7:0] lfsr_next(logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [ROWS-1:0] pipe_of(logic [7:0] l);
    int g;
    logic [ROWS-1:0] c;
    g = int'(l) % (ROWS - GAP + 1);
    for (int r = 0; r < ROWS; r++) c[r] = !(r >= g && r < g + GAP);
    return c;
  endfunction

  function automatic logic [COLS*ROWS-1:0] packf();
    logic [COLS*ROWS-1:0] f;
    for (int c = 0; c < COLS; c++) f[c*ROWS +: ROWS] = m_col[c];
    return f;
  endfunction

  function automatic logic [ROWS-1:0] gap_bird();
    if (m_col[BC] != '0)
      for (int r = 0; r < ROWS; r++) if (!m_col[BC][r]) return ROWS'(1) << r;
    return 8'b0001_0000;
  endfunction

  function automatic logic [ROWS-1:0] hit_bird();
    for (int r = 0; r < ROWS; r++) if (m_col[BC][r]) return ROWS'(1) << r;
    return 8'b0000_0001;
  endfunction

  task automatic chk(string tag, logic [COLS*ROWS-1:0] obs, logic [COLS*ROWS-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) m_col[c] = '0;
    m_score = 0; m_st = 0; m_cnt = 0; m_lfsr = SEED; m_sq = 1'b0;
  endtask

  task automatic model_step(logic s, logic c, logic [ROWS-1:0] b);
    logic rise;
    rise = s & ~m_sq;
    m_sq = s;
    if (m_st != 1) begin
      if (rise) begin
        m_st = 1; m_score = 0; m_cnt = 0;
        for (int i = 0; i < COLS; i++) m_col[i] = '0;
      end
    end else if ((m_col[BC] & b) != '0) begin
      m_st = 2;
    end else if (c) begin
      if (m_col[BC] != '0 && m_score < 99) m_score++;
      for (int i = 0; i < COLS - 1; i++) m_col[i] = m_col[i+1];
      if (m_cnt == 0) begin
        m_col[COLS-1] = pipe_of(m_lfsr);
        m_cnt = SP - 1;
      end else begin
        m_col[COLS-1] = '0;
        m_cnt--;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // called at a negedge; returns at the following negedge
  task automatic tick(logic s, logic c, logic [ROWS-1:0] b);
    exp_t e;
    start = s; cycle = c; bird_pos = b;
    model_step(s, c, b);
    q.push_back('{packf(), 7'(m_score), m_st == 1, m_st == 2});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pipes", pipes, e.pipes);
    chk("score", score, e.score);
    chk("playing", playing, e.playing);
    chk("game_over", game_over, e.game_over);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; cycle = 1'b0;
    #1;
    chk("rst_pipes", pipes, '0);
    chk("rst_score", score, '0);
    chk("rst_playing", playing, '0);
    chk("rst_game_over", game_over, '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [COLS*ROWS-1:0] snap_p;
  logic [6:0]           snap_s;
  int                   n;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: reset in the middle of a game with pipes on the field
    tick(1'b1, 1'b0, 8'h10);
    tick(1'b0, 1'b0, 8'h10);
    repeat (3) tick(1'b0, 1'b1, gap_bird());
    chk("t1_field_nonzero", pipes != '0, 1'b1);
    @(negedge clk);
    do_reset();
    tick(1'b1, 1'b0, 8'h10);
    chk("t1_playing", playing, 1'b1);

    // 2: insert the first pipe exactly when the LFSR holds the seed
    n = 0;
    while (m_lfsr != SEED && n < 300) begin
      tick(1'b0, 1'b0, 8'h10);
      n++;
    end
    chk("t2_seed_reached", m_lfsr == SEED, 1'b1);
    tick(1'b0, 1'b1, 8'h10);
    chk("t2_col15", pipes, {8'hC7, 120'b0});

    // 3: bird in row 4 stays inside the gap as the pipe passes
    repeat (13) tick(1'b0, 1'b1, 8'b0001_0000);
    chk("t3_at_col2", pipes[BC*ROWS +: ROWS], 8'hC7);
    chk("t3_score_before", score, 7'd0);
    tick(1'b0, 1'b1, 8'b0001_0000);
    chk("t3_score_after", score, 7'd1);
    chk("t3_no_over", game_over, 1'b0);

    // 4: bird on a lit pipe row ends the game; OVER ignores cycle
    n = 0;
    while (m_col[BC] == '0 && n < 20) begin
      tick(1'b0, 1'b1, gap_bird());
      n++;
    end
    chk("t4_pipe_arrived", m_col[BC] != '0, 1'b1);
    tick(1'b0, 1'b0, hit_bird());
    chk("t4_game_over", game_over, 1'b1);
    snap_p = pipes; snap_s = score;
    repeat (5) tick(1'b0, 1'b1, 8'h10);
    chk("t4_frozen_pipes", pipes, snap_p);
    chk("t4_frozen_score", score, snap_s);

    // 5: collision and cycle together, then restart
    tick(1'b1, 1'b0, 8'h10);
    chk("t5_restart_pipes", pipes, '0);
    chk("t5_restart_score", score, 7'd0);
    n = 0;
    while (m_col[BC] == '0 && n < 20) begin
      tick(1'b0, 1'b1, gap_bird());
      n++;
    end
    snap_p = packf();
    tick(1'b0, 1'b1, hit_bird());
    chk("t5_no_shift", pipes, snap_p);
    chk("t5_over", game_over, 1'b1);
    tick(1'b0, 1'b0, 8'h10);
    tick(1'b1, 1'b0, 8'h10);
    chk("t5_cleared_pipes", pipes, '0);
    chk("t5_cleared_score", score, 7'd0);
    chk("t5_playing", playing, 1'b1);

    // 6: fly through every gap until the score saturates
    repeat (440) tick(1'b0, 1'b1, gap_bird());
    chk("t6_score_99", score, 7'd99);
    repeat (20) tick(1'b0, 1'b1, gap_bird());
    chk("t6_score_hold", score, 7'd99);
    chk("t6_still_playing", playing, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
